// File: rtl/seq_divider_pkg.sv
// Shared types and sign helpers for the sequential divider.
// Helpers work on a fixed MAX_W-bit container; callers zero-extend their
// WIDTH-bit operands and take the low WIDTH bits of the result, which is
// exact because two's-complement negation of the low bits does not depend
// on the upper bits.
package seq_divider_pkg;

    localparam int MAX_W = 64;
    localparam int MSB_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negate when neg is set, pass through otherwise.
    function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

    // Magnitude of a WIDTH-bit value whose sign bit sits at index msb;
    // unsigned operands are returned unchanged.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                                 input logic is_signed,
                                                 input logic [MSB_W-1:0] msb);
        return neg_if(v, is_signed & v[msb]);
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational.
module seq_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {part_rem, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    // No borrow out of the subtraction means the divisor fits.
    assign quo_bit = ~diff[WIDTH];
    assign new_rem = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle,
// valid/ready on both sides, opaque tag and flush.
// Optional macro SEQ_DIVIDER_FASTPATH_EN: divide-by-zero, signed overflow and
// |dividend| < |divisor| skip the iterative steps and finish one cycle after
// acceptance.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             out_ovf
);

    // The counter runs 0..WIDTH: values below WIDTH perform a step, WIDTH is
    // the hand-off cycle into FIX, giving WIDTH+2 cycles from accept to DONE.
    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0]  MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_reg, state_next;
    logic               accept;

    logic [WIDTH-1:0]   rem_reg, quo_reg, divisor_reg, dividend_raw_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               q_neg_reg, r_neg_reg, dbz_reg, ovf_reg, lt_reg;
    logic [TAG_W-1:0]   tag_reg;

    logic [WIDTH-1:0]   quotient_reg, remainder_reg;
    logic [TAG_W-1:0]   out_tag_reg;
    logic               out_dbz_reg, out_ovf_reg;

    logic [WIDTH-1:0]   dvd_abs, dvs_abs, step_rem;
    logic               step_bit, is_dbz, is_ovf, is_lt, take_fast;

    assign dvd_abs = WIDTH'(abs_val(MAX_W'(in_dividend), in_signed, MSB_W'(WIDTH - 1)));
    assign dvs_abs = WIDTH'(abs_val(MAX_W'(in_divisor),  in_signed, MSB_W'(WIDTH - 1)));
    assign is_dbz  = (in_divisor == '0);
    assign is_ovf  = in_signed && (in_dividend == MIN_VAL) && (in_divisor == '1);

`ifdef SEQ_DIVIDER_FASTPATH_EN
    assign is_lt     = (dvd_abs < dvs_abs);
    assign take_fast = is_dbz | is_ovf | is_lt;
`else
    assign is_lt     = 1'b0;
    assign take_fast = 1'b0;
`endif

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .part_rem     (rem_reg),
        .dividend_bit (quo_reg[WIDTH-1]),
        .divisor      (divisor_reg),
        .new_rem      (step_rem),
        .quo_bit      (step_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next state and handshake outputs; flush overrides every transition.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = take_fast ? FIX : CALC;
                end
            end
            CALC: if (count_reg == LAST_CNT) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Operand capture, iterative steps and final sign/special-case fix-up.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg          <= '0;
            quo_reg          <= '0;
            divisor_reg      <= '0;
            dividend_raw_reg <= '0;
            count_reg        <= '0;
            q_neg_reg        <= 1'b0;
            r_neg_reg        <= 1'b0;
            dbz_reg          <= 1'b0;
            ovf_reg          <= 1'b0;
            lt_reg           <= 1'b0;
            tag_reg          <= '0;
            quotient_reg     <= '0;
            remainder_reg    <= '0;
            out_tag_reg      <= '0;
            out_dbz_reg      <= 1'b0;
            out_ovf_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    rem_reg          <= '0;
                    quo_reg          <= dvd_abs;
                    divisor_reg      <= dvs_abs;
                    dividend_raw_reg <= in_dividend;
                    count_reg        <= '0;
                    q_neg_reg        <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
                    r_neg_reg        <= in_signed & in_dividend[WIDTH-1];
                    dbz_reg          <= is_dbz;
                    ovf_reg          <= is_ovf;
                    lt_reg           <= is_lt;
                    tag_reg          <= in_tag;
                end
                CALC: begin
                    if (count_reg != LAST_CNT) begin
                        rem_reg <= step_rem;
                        quo_reg <= {quo_reg[WIDTH-2:0], step_bit};
                    end
                    count_reg <= count_reg + CNT_W'(1);
                end
                FIX: begin
                    out_tag_reg <= tag_reg;
                    out_dbz_reg <= dbz_reg;
                    out_ovf_reg <= ovf_reg;
                    if (dbz_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dividend_raw_reg;
                    end else if (ovf_reg) begin
                        quotient_reg  <= dividend_raw_reg;
                        remainder_reg <= '0;
                    end else if (lt_reg) begin
                        quotient_reg  <= '0;
                        remainder_reg <= dividend_raw_reg;
                    end else begin
                        quotient_reg  <= WIDTH'(neg_if(MAX_W'(quo_reg), q_neg_reg));
                        remainder_reg <= WIDTH'(neg_if(MAX_W'(rem_reg), r_neg_reg));
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_quotient  = quotient_reg;
    assign out_remainder = remainder_reg;
    assign out_tag       = out_tag_reg;
    assign out_dbz       = out_dbz_reg;
    assign out_ovf       = out_ovf_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed WIDTH=32 cases and a random
// WIDTH=8 sweep against an arithmetic reference model.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, v32, v8, out_ready, sgn, sel8;
    logic [31:0] dvd, dvs;
    logic [4:0]  tag_in;

    logic        rdy32, val32, dbz32, ovf32;
    logic [31:0] q32, r32;
    logic [4:0]  tag32;
    logic        rdy8, val8, dbz8, ovf8;
    logic [7:0]  q8, r8;
    logic [4:0]  tag8;

    seq_divider #(.WIDTH(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(v32), .in_ready(rdy32),
        .in_dividend(dvd), .in_divisor(dvs), .in_signed(sgn), .in_tag(tag_in),
        .out_valid(val32), .out_ready(out_ready),
        .out_quotient(q32), .out_remainder(r32), .out_tag(tag32),
        .out_dbz(dbz32), .out_ovf(ovf32)
    );

    seq_divider #(.WIDTH(8), .TAG_W(5)) u_dut8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(v8), .in_ready(rdy8),
        .in_dividend(dvd[7:0]), .in_divisor(dvs[7:0]), .in_signed(sgn), .in_tag(tag_in),
        .out_valid(val8), .out_ready(out_ready),
        .out_quotient(q8), .out_remainder(r8), .out_tag(tag8),
        .out_dbz(dbz8), .out_ovf(ovf8)
    );

    logic        obs_ready, obs_valid, obs_dbz, obs_ovf;
    logic [31:0] obs_q, obs_r;
    logic [4:0]  obs_tag;
    assign obs_ready = sel8 ? rdy8 : rdy32;
    assign obs_valid = sel8 ? val8 : val32;
    assign obs_dbz   = sel8 ? dbz8 : dbz32;
    assign obs_ovf   = sel8 ? ovf8 : ovf32;
    assign obs_q     = sel8 ? {24'b0, q8} : q32;
    assign obs_r     = sel8 ? {24'b0, r8} : r32;
    assign obs_tag   = sel8 ? tag8 : tag32;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on sign-extended values, RISC-V rules
    // for divide-by-zero and MIN/-1; fast marks the cases eligible for bypass.
    function automatic void ref_div(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                    input bit s, output logic [31:0] q, output logic [31:0] r,
                                    output bit dbz, output bit ovf, output bit fast);
        longint unsigned m, a, b;
        longint sa, sb, aa, ab;
        m = (64'd1 << w) - 64'd1;
        a = 64'(ai) & m;
        b = 64'(bi) & m;
        dbz = 1'b0; ovf = 1'b0; fast = 1'b0;
        sa = (s && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (s && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        if (b == 0) begin
            q = 32'(m); r = 32'(a); dbz = 1'b1; fast = 1'b1;
        end else if (s && a == (64'd1 << (w - 1)) && b == m) begin
            q = 32'(a); r = 32'd0; ovf = 1'b1; fast = 1'b1;
        end else begin
            q = 32'((sa / sb) & longint'(m));
            r = 32'((sa % sb) & longint'(m));
            aa = (sa < 0) ? -sa : sa;
            ab = (sb < 0) ? -sb : sb;
            fast = (aa < ab);
        end
    endfunction

    // One full transaction on the DUT picked by sel8, with 'hold' cycles of
    // back-pressure in DONE before the result is taken.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [4:0] t, input int hold);
        int w, exp_lat, lat;
        logic [31:0] eq, er;
        bit edbz, eovf, efast;
        w = sel8 ? 8 : 32;
        ref_div(w, a, b, s, eq, er, edbz, eovf, efast);
        exp_lat = w + 2;
`ifdef SEQ_DIVIDER_FASTPATH_EN
        if (efast) exp_lat = 1;
`endif
        check_eq("in_ready_idle", 32'(obs_ready), 32'd1);
        dvd = a; dvs = b; sgn = s; tag_in = t;
        if (sel8) v8 = 1'b1; else v32 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0; v32 = 1'b0;
        dvd = $urandom; dvs = $urandom; sgn = ~s; tag_in = ~t;
        lat = 0;
        while (!obs_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("quotient", obs_q, eq);
        check_eq("remainder", obs_r, er);
        check_eq("tag", 32'(obs_tag), 32'(t));
        check_eq("dbz", 32'(obs_dbz), 32'(edbz));
        check_eq("ovf", 32'(obs_ovf), 32'(eovf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(obs_valid), 32'd1);
            check_eq("hold_quotient", obs_q, eq);
            check_eq("hold_remainder", obs_r, er);
            check_eq("hold_tag", 32'(obs_tag), 32'(t));
            check_eq("hold_in_ready", 32'(obs_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("after_take_valid", 32'(obs_valid), 32'd0);
        check_eq("after_take_ready", 32'(obs_ready), 32'd1);
        $display("op w=%0d s=%0d a=0x%0h b=0x%0h tag=%0d q=0x%0h r=0x%0h dbz=%0d ovf=%0d lat=%0d",
                 w, s, a, b, t, obs_q, obs_r, obs_dbz, obs_ovf, lat);
    endtask

    initial begin
        bit seen;
        logic [31:0] ra, rb;
        reset = 1'b1; flush = 1'b0; v32 = 1'b0; v8 = 1'b0; out_ready = 1'b0;
        sgn = 1'b0; sel8 = 1'b0; dvd = '0; dvs = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of both instances.
        check_eq("rst_ready32", 32'(rdy32), 32'd1);
        check_eq("rst_valid32", 32'(val32), 32'd0);
        check_eq("rst_q32", q32, 32'd0);
        check_eq("rst_r32", r32, 32'd0);
        check_eq("rst_tag32", 32'(tag32), 32'd0);
        check_eq("rst_flags32", {30'd0, dbz32, ovf32}, 32'd0);
        check_eq("rst_ready8", 32'(rdy8), 32'd1);
        check_eq("rst_valid8", 32'(val8), 32'd0);

        // Directed WIDTH=32 cases.
        sel8 = 1'b0;
        run_op(32'd100, 32'd7, 1'b0, 5'h03, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 5'h04, 0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 5'h05, 0);
        run_op(32'h1234, 32'd0, 1'b0, 5'h06, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'h07, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'h08, 0);
        run_op(32'd12345678, 32'd1234, 1'b0, 5'h1a, 10);

        // Flush during CALC step 5.
        dvd = 32'd1000000; dvs = 32'd3; sgn = 1'b0; tag_in = 5'h11; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_ready", 32'(obs_ready), 32'd1);
        check_eq("flush_valid", 32'(obs_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (obs_valid) seen = 1'b1; end
        check_eq("flush_no_result", 32'(seen), 32'd0);
        run_op(32'd9, 32'd3, 1'b0, 5'h09, 0);

        // Flush coinciding with in_valid in IDLE accepts nothing.
        dvd = 32'd5; dvs = 32'd1; tag_in = 5'h0c; v32 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; flush = 1'b0;
        check_eq("flush_idle_ready", 32'(obs_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (obs_valid) seen = 1'b1; end
        check_eq("flush_idle_no_result", 32'(seen), 32'd0);

        // Reset while a result is pending clears everything.
        dvd = 32'hDEAD; dvs = 32'd7; sgn = 1'b0; tag_in = 5'h1f; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        for (int i = 0; i < 100 && !obs_valid; i++) begin @(posedge clk); #1; end
        check_eq("pre_reset_valid", 32'(obs_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("mid_rst_valid", 32'(obs_valid), 32'd0);
        check_eq("mid_rst_q", obs_q, 32'd0);
        check_eq("mid_rst_r", obs_r, 32'd0);
        check_eq("mid_rst_tag", 32'(obs_tag), 32'd0);
        check_eq("mid_rst_ready", 32'(obs_ready), 32'd1);

        // WIDTH=8: small-dividend case, then random sweep.
        sel8 = 1'b1;
        run_op(32'd3, 32'd200, 1'b0, 5'h02, 0);
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 15) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h80; rb = 32'hFF; end
            run_op(ra, rb, 1'($urandom_range(0, 1)), 5'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
